// File: rtl/led_scan_mux.sv
// led_scan_mux: multiplexed LED/seven-segment scanner with anti-ghost blanking, PWM and tear-free double buffering
// Ports: clk_i/rst_i clock and async active-high reset; enable_i scan enable;
//   data_i/valid_i/ready_o display-word handshake (byte k = digit k, {dp,g..a});
//   bright_i PWM brightness; seg_o/sel_o segment and digit drive; frame_o frame-boundary pulse.
module led_scan_mux #(
  parameter int   NUM_DIGITS   = 3,
  parameter int   CLK_IN_MHZ   = 12,
  parameter int   DIGIT_US     = 500,
  parameter int   BLANK_CYCLES = 8,
  parameter int   PWM_BITS     = 4,
  parameter logic SEG_ACTIVE   = 1'b1,
  parameter logic SEL_ACTIVE   = 1'b0
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic [NUM_DIGITS*8-1:0] data_i,
  input  logic                    valid_i,
  output logic                    ready_o,
  input  logic [PWM_BITS-1:0]     bright_i,
  output logic [7:0]              seg_o,
  output logic [NUM_DIGITS-1:0]   sel_o,
  output logic                    frame_o
);
  localparam int SLOT_CYCLES = CLK_IN_MHZ * DIGIT_US;
  localparam int CW = $clog2(SLOT_CYCLES);
  localparam int DW = $clog2(NUM_DIGITS);
  typedef enum logic [1:0] {IDLE, BLANK, ON} state_t;
  state_t                  r_state, w_state_n;
  logic [CW-1:0]           r_cnt, w_cnt_n;
  logic [DW-1:0]           r_dig, w_dig_n;
  logic [PWM_BITS-1:0]     r_pwm, w_pwm_n;
  logic [NUM_DIGITS*8-1:0] r_shadow, r_active, w_active_n;
  logic [7:0]              r_seg, w_byte;
  logic [NUM_DIGITS-1:0]   r_sel, w_onehot;
  logic                    r_ready, r_arm, r_frame;
  logic                    w_run, w_slot_end, w_wrap, w_copy, w_acc, w_lit;
  assign ready_o = r_ready;
  assign seg_o   = r_seg;
  assign sel_o   = r_sel;
  assign frame_o = r_frame;
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) r_state <= IDLE;
    else       r_state <= w_state_n;
  // r_cnt runs across the whole slot: values below BLANK_CYCLES are the blank
  // window, the rest is the lit window.
  always_comb begin
    w_run      = enable_i && r_state != IDLE;
    w_slot_end = r_state == ON && r_cnt == CW'(SLOT_CYCLES - 1);
    w_wrap     = w_slot_end && r_dig == DW'(NUM_DIGITS - 1);
    w_cnt_n    = (w_run && !w_slot_end) ? r_cnt + 1'b1 : '0;
    w_state_n  = !enable_i ? IDLE : (w_cnt_n < CW'(BLANK_CYCLES) ? BLANK : ON);
    w_dig_n    = (!w_run || w_wrap) ? '0 : (w_slot_end ? r_dig + 1'b1 : r_dig);
    w_pwm_n    = r_state == ON ? r_pwm + 1'b1 : '0;
    // r_arm captures pending as it stood before the boundary edge, so a word
    // accepted at or during the boundary waits for the following frame.
    w_copy     = !r_ready && (r_arm || r_state == IDLE);
    w_acc      = valid_i && r_ready;
    w_active_n = w_copy ? r_shadow : r_active;
    w_byte     = w_active_n[8*w_dig_n +: 8];
    w_onehot   = NUM_DIGITS'(1) << w_dig_n;
    w_lit      = w_state_n == ON && (w_pwm_n < bright_i || &bright_i);
  end
  // Outputs are registered from next-state values so they line up with r_state.
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      r_cnt    <= '0;
      r_dig    <= '0;
      r_pwm    <= '0;
      r_shadow <= '0;
      r_active <= '0;
      r_ready  <= 1'b1;
      r_arm    <= 1'b0;
      r_frame  <= 1'b0;
      r_seg    <= {8{~SEG_ACTIVE}};
      r_sel    <= {NUM_DIGITS{~SEL_ACTIVE}};
    end else begin
      r_cnt    <= w_cnt_n;
      r_dig    <= w_dig_n;
      r_pwm    <= w_pwm_n;
      r_shadow <= w_acc ? data_i : r_shadow;
      r_active <= w_active_n;
      r_ready  <= w_acc ? 1'b0 : (w_copy ? 1'b1 : r_ready);
      r_arm    <= w_wrap && !r_ready;
      r_frame  <= w_wrap && enable_i;
      r_seg    <= {8{~SEG_ACTIVE}} ^ (w_lit ? w_byte : 8'h00);
      r_sel    <= {NUM_DIGITS{~SEL_ACTIVE}} ^ (w_state_n == ON ? w_onehot : '0);
    end
endmodule

// File: tb/tb_led_scan_mux.sv
// tb_led_scan_mux: directed self-checking bench for led_scan_mux
module tb_led_scan_mux;
  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        enable_i;
  logic [23:0] data_i;
  logic        valid_i;
  logic        ready_o;
  logic [1:0]  bright_i;
  logic [7:0]  seg_o;
  logic [2:0]  sel_o;
  logic        frame_o;
  int n_run = 0;
  int n_fail = 0;
  led_scan_mux #(
    .NUM_DIGITS(3), .CLK_IN_MHZ(1), .DIGIT_US(16), .BLANK_CYCLES(2),
    .PWM_BITS(2), .SEG_ACTIVE(1'b1), .SEL_ACTIVE(1'b0)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .enable_i(enable_i), .data_i(data_i),
    .valid_i(valid_i), .ready_o(ready_o), .bright_i(bright_i),
    .seg_o(seg_o), .sel_o(sel_o), .frame_o(frame_o)
  );
  always #5 clk_i = ~clk_i;
  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic [2:0] s, input logic [7:0] g);
    chk({tag, ".sel"}, 32'(sel_o), 32'(s));
    chk({tag, ".seg"}, 32'(seg_o), 32'(g));
  endtask
  initial begin
    rst_i = 1'b1; enable_i = 1'b0; valid_i = 1'b0; data_i = '0; bright_i = 2'b11;
    tick(2);
    chk_out("rst", 3'b111, 8'h00);
    chk("rst.ready", 32'(ready_o), 1);
    chk("rst.frame", 32'(frame_o), 0);
    rst_i = 1'b0;
    tick(3);
    chk_out("idle", 3'b111, 8'h00);
    valid_i = 1'b1; data_i = 24'h3F065B;
    tick(1);
    chk("idle_acc.ready", 32'(ready_o), 0);
    valid_i = 1'b0;
    tick(1);
    chk("idle_copy.ready", 32'(ready_o), 1);
    enable_i = 1'b1;
    tick(1);  chk_out("blank0a", 3'b111, 8'h00);
    tick(1);  chk_out("blank0b", 3'b111, 8'h00);
    tick(1);  chk_out("on0_first", 3'b110, 8'h5B);
    tick(13); chk_out("on0_last", 3'b110, 8'h5B);
    tick(1);  chk_out("blank1", 3'b111, 8'h00);
    tick(2);  chk_out("on1", 3'b101, 8'h06);
    tick(16); chk_out("on2", 3'b011, 8'h3F);
    tick(13); chk("frame_pre", 32'(frame_o), 0);
    chk_out("on2_last", 3'b011, 8'h3F);
    tick(1);  chk("frame1", 32'(frame_o), 1);
    chk_out("frame1_blank", 3'b111, 8'h00);
    tick(1);  chk("frame1_end", 32'(frame_o), 0);
    tick(46); chk("frame2_pre", 32'(frame_o), 0);
    tick(1);  chk("frame2", 32'(frame_o), 1);
    bright_i = 2'b01;
    tick(2);  chk_out("pwm1_c0", 3'b110, 8'h5B);
    tick(1);  chk_out("pwm1_c1", 3'b110, 8'h00);
    tick(3);  chk_out("pwm1_c4", 3'b110, 8'h5B);
    bright_i = 2'b00;
    tick(4);  chk_out("pwm0_c8", 3'b110, 8'h00);
    tick(8);  chk_out("pwm0_dig1", 3'b101, 8'h00);
    bright_i = 2'b11; valid_i = 1'b1; data_i = 24'hFFFFFF;
    tick(1);
    chk("tear_acc.ready", 32'(ready_o), 0);
    chk_out("tear_old1", 3'b101, 8'h06);
    data_i = 24'h112233;
    tick(15); chk_out("tear_old2", 3'b011, 8'h3F);
    chk("bp_hold.ready", 32'(ready_o), 0);
    tick(14); chk("tear_frame", 32'(frame_o), 1);
    chk("tear_frame.ready", 32'(ready_o), 0);
    tick(1);  chk("tear_after.ready", 32'(ready_o), 1);
    tick(1);  chk("bp_acc.ready", 32'(ready_o), 0);
    chk_out("tear_new0", 3'b110, 8'hFF);
    valid_i = 1'b0;
    tick(16); chk_out("tear_new1", 3'b101, 8'hFF);
    tick(32); chk_out("bp_applied", 3'b110, 8'h33);
    chk("bp_applied.ready", 32'(ready_o), 1);
    tick(45);
    valid_i = 1'b1; data_i = 24'hAABBCC;
    tick(1);  chk("coll_frame", 32'(frame_o), 1);
    chk("coll_acc.ready", 32'(ready_o), 0);
    tick(1);  chk("coll_nocopy.ready", 32'(ready_o), 0);
    valid_i = 1'b0;
    tick(1);  chk_out("coll_old", 3'b110, 8'h33);
    tick(48); chk_out("coll_new", 3'b110, 8'hCC);
    chk("coll_new.ready", 32'(ready_o), 1);
    tick(32); chk_out("dis_on2", 3'b011, 8'hAA);
    valid_i = 1'b1; data_i = 24'h445566;
    tick(1);  chk_out("dis_on2b", 3'b011, 8'hAA);
    chk("dis_acc.ready", 32'(ready_o), 0);
    enable_i = 1'b0; valid_i = 1'b0;
    tick(1);  chk_out("dis_idle", 3'b111, 8'h00);
    chk("dis_idle.ready", 32'(ready_o), 0);
    tick(1);  chk("dis_copy.ready", 32'(ready_o), 1);
    enable_i = 1'b1;
    tick(1);  chk_out("reen_blank", 3'b111, 8'h00);
    tick(2);  chk_out("reen_on0", 3'b110, 8'h66);
    valid_i = 1'b1; data_i = 24'h000000;
    tick(1);  chk("pre_rst.ready", 32'(ready_o), 0);
    valid_i = 1'b0;
    #2;
    rst_i = 1'b1; enable_i = 1'b0;
    #1;
    chk_out("async_rst", 3'b111, 8'h00);
    chk("async_rst.ready", 32'(ready_o), 1);
    tick(1);
    rst_i = 1'b0;
    tick(3);
    chk_out("post_rst", 3'b111, 8'h00);
    chk("post_rst.ready", 32'(ready_o), 1);
    chk("post_rst.frame", 32'(frame_o), 0);
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
